// File: rtl/stream_upsizer_if.sv
// Stream upsizer handshake bundle: narrow input beats on the s_* side,
// packed wide words on the m_* side. The upsizer takes the slave view.
interface stream_upsizer_if #(
   parameter int DW_IN = 8,
   parameter int SCALE = 4
);
   localparam int CW = $clog2(SCALE + 1);

   logic [DW_IN-1:0]       s_data_i;
   logic                   s_valid_i;
   logic                   s_last_i;
   logic                   s_ready_o;
   logic [DW_IN*SCALE-1:0] m_data_o;
   logic [CW-1:0]          m_count_o;
   logic                   m_last_o;
   logic                   m_valid_o;
   logic                   m_ready_i;

   modport slave (
      input  s_data_i, s_valid_i, s_last_i, m_ready_i,
      output s_ready_o, m_data_o, m_count_o, m_last_o, m_valid_o
   );

   modport master (
      output s_data_i, s_valid_i, s_last_i, m_ready_i,
      input  s_ready_o, m_data_o, m_count_o, m_last_o, m_valid_o
   );
endinterface

// File: rtl/stream_upsizer.sv
// Packs SCALE narrow beats (lane-ascending) into one wide word. A word is
// emitted when the last lane fills or the beat carries s_last_i; unused upper
// lanes are zero and m_count_o reports how many lanes are valid.
module stream_upsizer #(
   parameter int DW_IN = 8,
   parameter int SCALE = 4
) (
   input  logic            clk,
   input  logic            rst,
   stream_upsizer_if.slave bus
);
   localparam int CW = $clog2(SCALE + 1);
   localparam int IW = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int OW = DW_IN * SCALE;

   logic          r_rst;
   logic [IW-1:0] r_idx;
   logic [OW-1:0] r_acc;
   logic [OW-1:0] r_data;
   logic [CW-1:0] r_count;
   logic          r_last;
   logic          r_valid;

   logic          w_ready;
   logic          w_wr;
   logic          w_rd;
   logic          w_complete;
   logic [OW-1:0] w_word;

   // Ready depends only on registered state, rst and m_ready_i, never on
   // s_valid_i; it stays low while rst is high and for one cycle after.
   assign w_ready    = !rst && !r_rst && (!r_valid || bus.m_ready_i);
   assign w_wr       = bus.s_valid_i && w_ready;
   assign w_rd       = r_valid && bus.m_ready_i;
   assign w_complete = w_wr && ((r_idx == IW'(SCALE - 1)) || bus.s_last_i);

   // Accumulator with the incoming beat dropped into the current lane; lanes
   // above idx are already zero because the accumulator is cleared per word.
   always_comb begin
      w_word = r_acc;
      w_word[int'(r_idx)*DW_IN +: DW_IN] = bus.s_data_i;
   end

   // Reset shadow that holds off input acceptance for a cycle after reset.
   always_ff @(posedge clk) begin
      r_rst <= rst;
   end

   // Lane packing and output word register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_count <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_complete) begin
         r_data  <= w_word;
         r_count <= CW'(r_idx) + CW'(1);
         r_last  <= bus.s_last_i;
         r_valid <= 1'b1;
         r_idx   <= '0;
         r_acc   <= '0;
      end else begin
         if (w_wr) begin
            r_acc <= w_word;
            r_idx <= r_idx + IW'(1);
         end
         if (w_rd) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.s_ready_o = w_ready;
   assign bus.m_data_o  = r_data;
   assign bus.m_count_o = r_count;
   assign bus.m_last_o  = r_last;
   assign bus.m_valid_o = r_valid;
endmodule

// File: tb/tb_stream_upsizer.sv
// Directed vector table plus hand-written sequences for throughput, reset
// mid-word and a randomised SCALE=1 pass-through against a small model.
module tb_stream_upsizer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   stream_upsizer_if #(.DW_IN(8), .SCALE(4)) b4 ();
   stream_upsizer_if #(.DW_IN(8), .SCALE(1)) b1 ();

   stream_upsizer #(.DW_IN(8), .SCALE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
   stream_upsizer #(.DW_IN(8), .SCALE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        mr;
      logic        rdy;
      logic        mv;
      logic [31:0] md;
      logic [2:0]  mc;
      logic        ml;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_w;
      logic [7:0]  bt;
      int          words;
      logic        mv, ml, wr, exp_rdy, v, l, mr;
      logic [7:0]  md, d;
      int          n_in, n_out;

      b4.s_valid_i = 0; b4.s_data_i = 0; b4.s_last_i = 0; b4.m_ready_i = 1;
      b1.s_valid_i = 0; b1.s_data_i = 0; b1.s_last_i = 0; b1.m_ready_i = 1;

      // ---------------- reset state ----------------
      repeat (3) edge1();
      chk("rst_ready", 64'(b4.s_ready_o), 64'(0));
      chk("rst_valid", 64'(b4.m_valid_o), 64'(0));
      chk("rst_data",  64'(b4.m_data_o),  64'(0));
      chk("rst_count", 64'(b4.m_count_o), 64'(0));
      chk("rst_last",  64'(b4.m_last_o),  64'(0));
      rst = 0;
      #1;
      chk("rst_ready_hold", 64'(b4.s_ready_o), 64'(0));
      edge1();
      chk("rst_ready_rel", 64'(b4.s_ready_o), 64'(1));

      // ---------------- vector table ----------------
      //            v   d      l  mr  rdy mv  md            mc ml
      vq.push_back('{1, 8'h11, 0, 1,  1,  0,  32'h00000000, 0, 0});
      vq.push_back('{1, 8'h22, 0, 1,  1,  0,  32'h00000000, 0, 0});
      vq.push_back('{1, 8'h33, 0, 1,  1,  0,  32'h00000000, 0, 0});
      vq.push_back('{1, 8'h44, 0, 1,  1,  1,  32'h44332211, 4, 0});
      vq.push_back('{1, 8'hAA, 0, 1,  1,  0,  32'h44332211, 4, 0});
      vq.push_back('{1, 8'hBB, 1, 1,  1,  1,  32'h0000BBAA, 2, 1});
      vq.push_back('{1, 8'h55, 0, 1,  1,  0,  32'h0000BBAA, 2, 1});
      vq.push_back('{1, 8'h66, 0, 1,  1,  0,  32'h0000BBAA, 2, 1});
      vq.push_back('{1, 8'h77, 0, 1,  1,  0,  32'h0000BBAA, 2, 1});
      vq.push_back('{1, 8'h88, 1, 1,  1,  1,  32'h88776655, 4, 1});
      vq.push_back('{0, 8'hFF, 1, 1,  1,  0,  32'h88776655, 4, 1});
      vq.push_back('{0, 8'hEE, 1, 1,  1,  0,  32'h88776655, 4, 1});
      vq.push_back('{1, 8'h01, 1, 0,  1,  1,  32'h00000001, 1, 1});
      for (int i = 0; i < 5; i++)
         vq.push_back('{1, 8'h99, 0, 0, 0, 1, 32'h00000001, 1, 1});
      vq.push_back('{1, 8'h02, 0, 1,  1,  0,  32'h00000001, 1, 1});
      vq.push_back('{1, 8'h03, 1, 1,  1,  1,  32'h00000302, 2, 1});
      vq.push_back('{1, 8'h04, 1, 1,  1,  1,  32'h00000004, 1, 1});
      vq.push_back('{0, 8'h00, 0, 1,  1,  0,  32'h00000004, 1, 1});

      foreach (vq[i]) begin
         b4.s_valid_i = vq[i].v;
         b4.s_data_i  = vq[i].d;
         b4.s_last_i  = vq[i].l;
         b4.m_ready_i = vq[i].mr;
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(b4.s_ready_o), 64'(vq[i].rdy));
         edge1();
         chk($sformatf("vec%0d_valid", i), 64'(b4.m_valid_o), 64'(vq[i].mv));
         chk($sformatf("vec%0d_data", i),  64'(b4.m_data_o),  64'(vq[i].md));
         chk($sformatf("vec%0d_count", i), 64'(b4.m_count_o), 64'(vq[i].mc));
         chk($sformatf("vec%0d_last", i),  64'(b4.m_last_o),  64'(vq[i].ml));
      end

      // ---------------- full throughput: 12 beats ----------------
      words = 0;
      b4.m_ready_i = 1;
      b4.s_last_i  = 0;
      for (int i = 0; i < 12; i++) begin
         b4.s_valid_i = 1;
         b4.s_data_i  = 8'(8'h10 + i);
         #1;
         chk("thr_ready", 64'(b4.s_ready_o), 64'(1));
         edge1();
         chk($sformatf("thr%0d_valid", i), 64'(b4.m_valid_o), 64'((i % 4) == 3));
         if (b4.m_valid_o) begin
            words++;
            for (int k = 0; k < 4; k++) begin
               bt = 8'(8'h10 + i - 3 + k);
               exp_w[k*8 +: 8] = bt;
            end
            chk("thr_data",  64'(b4.m_data_o),  64'(exp_w));
            chk("thr_count", 64'(b4.m_count_o), 64'(4));
            chk("thr_last",  64'(b4.m_last_o),  64'(0));
         end
      end
      b4.s_valid_i = 0;
      edge1();
      chk("thr_drain_valid", 64'(b4.m_valid_o), 64'(0));
      chk("thr_words", 64'(words), 64'(3));

      // ---------------- reset mid-word ----------------
      b4.s_valid_i = 1; b4.s_data_i = 8'hA1; edge1();
      b4.s_data_i = 8'hA2; edge1();
      b4.s_valid_i = 0;
      rst = 1;
      #1;
      chk("mid_rst_ready", 64'(b4.s_ready_o), 64'(0));
      edge1();
      chk("mid_rst_valid", 64'(b4.m_valid_o), 64'(0));
      chk("mid_rst_data",  64'(b4.m_data_o),  64'(0));
      rst = 0;
      #1;
      chk("mid_rst_ready_hold", 64'(b4.s_ready_o), 64'(0));
      edge1();
      chk("mid_rst_ready_rel", 64'(b4.s_ready_o), 64'(1));
      for (int i = 1; i <= 4; i++) begin
         b4.s_valid_i = 1;
         b4.s_data_i  = 8'(i);
         edge1();
         chk($sformatf("post_rst%0d_valid", i), 64'(b4.m_valid_o), 64'(i == 4));
      end
      chk("post_rst_data",  64'(b4.m_data_o),  64'(32'h04030201));
      chk("post_rst_count", 64'(b4.m_count_o), 64'(4));
      chk("post_rst_last",  64'(b4.m_last_o),  64'(0));
      b4.s_valid_i = 0;
      edge1();

      // ---------------- SCALE=1 random pass-through ----------------
      mv = 0; md = 0; ml = 0; n_in = 0; n_out = 0;
      for (int c = 0; c < 300; c++) begin
         v  = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         l  = 1'($urandom_range(0, 1));
         mr = 1'($urandom_range(0, 1));
         b1.s_valid_i = v; b1.s_data_i = d; b1.s_last_i = l; b1.m_ready_i = mr;
         #1;
         exp_rdy = !mv || mr;
         chk("s1_ready", 64'(b1.s_ready_o), 64'(exp_rdy));
         wr = v && exp_rdy;
         if (mv && mr) n_out++;
         if (wr) begin
            mv = 1; md = d; ml = l; n_in++;
         end else if (mv && mr) begin
            mv = 0;
         end
         edge1();
         chk("s1_valid", 64'(b1.m_valid_o), 64'(mv));
         if (mv) begin
            chk("s1_data",  64'(b1.m_data_o),  64'(md));
            chk("s1_count", 64'(b1.m_count_o), 64'(1));
            chk("s1_last",  64'(b1.m_last_o),  64'(ml));
         end
      end
      b1.s_valid_i = 0;
      b1.m_ready_i = 1;
      edge1();
      if (mv) n_out++;
      chk("s1_inout", 64'(n_out), 64'(n_in));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
